// File: rtl/box_drawer_pkg.sv
// ============================================================================
//  Module   : box_draw_pkg
//  Purpose  : Shared state encoding and screen defaults for box_drawer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package box_draw_pkg;

  localparam int c_DEF_SCREEN_W = 160;
  localparam int c_DEF_SCREEN_H = 120;
  localparam int c_DEF_COLOUR_W = 3;
  localparam int c_BLACK        = 0;

  localparam int c_STATE_W = 3;
  typedef logic [c_STATE_W-1:0] state_t;

  localparam state_t c_ST_LOAD_X      = 3'd0;
  localparam state_t c_ST_LOAD_X_WAIT = 3'd1;
  localparam state_t c_ST_LOAD_Y      = 3'd2;
  localparam state_t c_ST_LOAD_Y_WAIT = 3'd3;
  localparam state_t c_ST_DRAW        = 3'd4;
  localparam state_t c_ST_DONE        = 3'd5;
  localparam state_t c_ST_CLEAR       = 3'd6;

endpackage

`default_nettype wire

// File: rtl/box_drawer_if.sv
// ============================================================================
//  Module   : box_drawer_if
//  Purpose  : Coordinate/command inputs and plot outputs of box_drawer.
//             clear_req exists only with BOX_DRAWER_CLEAR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface box_drawer_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) ();

  logic [X_W-1:0]      data_in;
  logic [COLOUR_W-1:0] colour_in;
  logic                go;
`ifdef BOX_DRAWER_CLEAR_EN
  logic                clear_req;
`endif
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

`ifdef BOX_DRAWER_CLEAR_EN
  modport master (
    output data_in, colour_in, go, clear_req,
    input  x, y, colour, plot, busy, done
  );
  modport slave (
    input  data_in, colour_in, go, clear_req,
    output x, y, colour, plot, busy, done
  );
`else
  modport master (
    output data_in, colour_in, go,
    input  x, y, colour, plot, busy, done
  );
  modport slave (
    input  data_in, colour_in, go,
    output x, y, colour, plot, busy, done
  );
`endif

endinterface

`default_nettype wire

// File: rtl/box_drawer_offset_counter_2d.sv
// ============================================================================
//  Module   : offset_counter_2d
//  Purpose  : Raster-order 2-D counter, inner loop fastest, runtime limits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module offset_counter_2d #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [IN_W-1:0]  i_in_max,
  input  logic [OUT_W-1:0] i_out_max,
  output logic [IN_W-1:0]  o_inner,
  output logic [OUT_W-1:0] o_outer,
  output logic             o_last
);

  logic [IN_W-1:0]  r_inner;
  logic [OUT_W-1:0] r_outer;
  logic             w_in_wrap;
  logic             w_out_wrap;

  assign w_in_wrap  = (r_inner == i_in_max);
  assign w_out_wrap = (r_outer == i_out_max);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_inner <= '0;
      r_outer <= '0;
    end else if (i_en) begin
      if (w_in_wrap) begin
        r_inner <= '0;
        r_outer <= w_out_wrap ? '0 : r_outer + 1'b1;
      end else begin
        r_inner <= r_inner + 1'b1;
      end
    end
  end

  assign o_inner = r_inner;
  assign o_outer = r_outer;
  assign o_last  = w_in_wrap && w_out_wrap;

endmodule

`default_nettype wire

// File: rtl/box_drawer.sv
// ============================================================================
//  Module   : box_drawer
//  Purpose  : Loads a box origin over a go handshake, then plots a filled
//             BOX_W x BOX_H box one pixel per cycle. Optional full-screen
//             clear enabled by BOX_DRAWER_CLEAR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module box_drawer
  import box_draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = c_DEF_SCREEN_W,
  parameter int SCREEN_H = c_DEF_SCREEN_H,
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int COLOUR_W = c_DEF_COLOUR_W
) (
  input  logic        clk,
  input  logic        reset,
  box_drawer_if.slave bus
);

  localparam logic [X_W-1:0]      c_DRAW_X_MAX  = X_W'(BOX_W - 1);
  localparam logic [Y_W-1:0]      c_DRAW_Y_MAX  = Y_W'(BOX_H - 1);
  localparam logic [X_W-1:0]      c_CLEAR_X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]      c_CLEAR_Y_MAX = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]        c_X_LIMIT     = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]        c_Y_LIMIT     = (Y_W+1)'(SCREEN_H);
  localparam logic [COLOUR_W-1:0] c_COLOUR_BLK  = COLOUR_W'(c_BLACK);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [X_W-1:0]      r_origin_x;
  logic [Y_W-1:0]      r_origin_y;
  logic [COLOUR_W-1:0] r_colour_lat;

  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_plot;
  logic                r_busy;
  logic                r_done;

  logic                w_draw;
  logic                w_clear_mode;
  logic                w_start_draw;
  logic                w_start_clear;
  logic [X_W-1:0]      w_cx;
  logic [Y_W-1:0]      w_cy;
  logic                w_cnt_last;
  logic [X_W-1:0]      w_in_max;
  logic [Y_W-1:0]      w_out_max;
  logic [X_W-1:0]      w_base_x;
  logic [Y_W-1:0]      w_base_y;
  logic [X_W:0]        w_sum_x;
  logic [Y_W:0]        w_sum_y;
  logic                w_on_screen;

  logic                w_pix_load;
  logic                w_plot_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [COLOUR_W-1:0] w_pix_colour;

  assign w_draw       = (r_state == c_ST_DRAW);
  assign w_start_draw = (r_state == c_ST_LOAD_Y_WAIT) && !bus.go;

`ifdef BOX_DRAWER_CLEAR_EN
  assign w_clear_mode  = (r_state == c_ST_CLEAR);
  assign w_start_clear = (r_state == c_ST_LOAD_X) && bus.clear_req;
`else
  assign w_clear_mode  = 1'b0;
  assign w_start_clear = 1'b0;
`endif

  // One counter serves both the box and the full-screen sweep.
  assign w_in_max  = w_clear_mode ? c_CLEAR_X_MAX : c_DRAW_X_MAX;
  assign w_out_max = w_clear_mode ? c_CLEAR_Y_MAX : c_DRAW_Y_MAX;

  offset_counter_2d #(
    .IN_W  (X_W),
    .OUT_W (Y_W)
  ) u_offset_counter (
    .clk       (clk),
    .rst       (reset),
    .i_en      (w_draw || w_clear_mode),
    .i_clr     (w_start_draw || w_start_clear),
    .i_in_max  (w_in_max),
    .i_out_max (w_out_max),
    .o_inner   (w_cx),
    .o_outer   (w_cy),
    .o_last    (w_cnt_last)
  );

  // Sums keep the carry so off-screen pixels never wrap back into view.
  assign w_base_x    = w_clear_mode ? '0 : r_origin_x;
  assign w_base_y    = w_clear_mode ? '0 : r_origin_y;
  assign w_sum_x     = {1'b0, w_base_x} + {1'b0, w_cx};
  assign w_sum_y     = {1'b0, w_base_y} + {1'b0, w_cy};
  assign w_on_screen = (w_sum_x < c_X_LIMIT) && (w_sum_y < c_Y_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_LOAD_X;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_LOAD_X: begin
`ifdef BOX_DRAWER_CLEAR_EN
        if (bus.clear_req) w_state_nxt = c_ST_CLEAR;
        else
`endif
        if (bus.go)        w_state_nxt = c_ST_LOAD_X_WAIT;
      end
      c_ST_LOAD_X_WAIT: if (!bus.go) w_state_nxt = c_ST_LOAD_Y;
      c_ST_LOAD_Y:      if (bus.go)  w_state_nxt = c_ST_LOAD_Y_WAIT;
      c_ST_LOAD_Y_WAIT: if (!bus.go) w_state_nxt = c_ST_DRAW;
      c_ST_DRAW:        if (w_cnt_last) w_state_nxt = c_ST_DONE;
`ifdef BOX_DRAWER_CLEAR_EN
      c_ST_CLEAR:       if (w_cnt_last) w_state_nxt = c_ST_DONE;
`endif
      c_ST_DONE:        w_state_nxt = c_ST_LOAD_X;
      default:          w_state_nxt = c_ST_LOAD_X;
    endcase
  end

  always_comb begin
    w_pix_load   = (w_draw && w_on_screen) || w_clear_mode;
    w_plot_nxt   = w_pix_load;
    w_busy_nxt   = w_draw || w_clear_mode;
    w_done_nxt   = (r_state == c_ST_DONE);
    w_pix_colour = w_clear_mode ? c_COLOUR_BLK : r_colour_lat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_origin_x   <= '0;
      r_origin_y   <= '0;
      r_colour_lat <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (r_state == c_ST_LOAD_X) r_origin_x <= bus.data_in;
      if (r_state == c_ST_LOAD_Y) r_origin_y <= bus.data_in[Y_W-1:0];
      if (w_start_draw)           r_colour_lat <= bus.colour_in;
      r_plot <= w_plot_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      // Pixel outputs only move when a pixel is actually written.
      if (w_pix_load) begin
        r_x      <= w_sum_x[X_W-1:0];
        r_y      <= w_sum_y[Y_W-1:0];
        r_colour <= w_pix_colour;
      end
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_box_drawer.sv
// ============================================================================
//  Module   : tb_box_drawer
//  Purpose  : Randomised scoreboard bench for box_drawer (clear test runs
//             when BOX_DRAWER_CLEAR_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_box_drawer;

  localparam int X_W = 8, Y_W = 7, COLOUR_W = 3;
  localparam int SW = 160, SH = 120, BW = 4, BH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  box_drawer_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

  box_drawer #(
    .X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH),
    .BOX_W(BW), .BOX_H(BH), .COLOUR_W(COLOUR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   done_q[$];
  int   total = 0, bad = 0;
  int   n_done = 0, n_plot = 0;
  int   busy_run = 0;
  bit   prev_busy = 1'b0;

  // Monitor: compares every presented pixel and done pulse with the queues.
  always @(negedge clk) begin
    pix_t p;
    int   e;
    if (reset) begin
      busy_run  = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.plot) begin
        n_plot++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) want none", bus.x, bus.y, bus.colour);
        end else begin
          p = exp_q.pop_front();
          if (bus.x !== p.x || bus.y !== p.y || bus.colour !== p.c) begin
            bad++;
            $display("FAIL pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     bus.x, bus.y, bus.colour, p.x, p.y, p.c);
          end
        end
      end
      if (bus.done) begin
        n_done++;
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got done=1 want 0");
        end else begin
          e = done_q.pop_front();
          if (busy_run != e || bus.busy || !prev_busy || exp_q.size() != 0) begin
            bad++;
            $display("FAIL done_check: got busy_run=%0d busy=%0b prev_busy=%0b pending=%0d want %0d,0,1,0",
                     busy_run, bus.busy, prev_busy, exp_q.size(), e);
          end
        end
      end
      if (bus.busy) busy_run++;
      else          busy_run = 0;
      prev_busy = bus.busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model: every on-screen pixel of the box, raster order.
  task automatic expect_box(input int ox, input int oy, input int col);
    pix_t p;
    for (int cy = 0; cy < BH; cy++) begin
      for (int cx = 0; cx < BW; cx++) begin
        if (ox + cx < SW && oy + cy < SH) begin
          p.x = X_W'(ox + cx);
          p.y = Y_W'(oy + cy);
          p.c = COLOUR_W'(col);
          exp_q.push_back(p);
        end
      end
    end
    done_q.push_back(BW * BH);
  endtask

  task automatic load_x(input int xv);
    bus.data_in = X_W'(xv);
    cyc(2);
    bus.go = 1'b1;
    cyc(2);
    bus.go = 1'b0;
    cyc(1);
  endtask

  task automatic load_y_start(input int xv, input int yv);
    bus.data_in = X_W'(yv);
    cyc(2);
    bus.go = 1'b1;
    cyc(2);
    expect_box(xv, yv % (1 << Y_W), int'(bus.colour_in));
    bus.go = 1'b0;
    cyc(1);
  endtask

  task automatic draw_box(input int xv, input int yv, input int col);
    bus.colour_in = COLOUR_W'(col);
    load_x(xv);
    load_y_start(xv, yv);
  endtask

  task automatic wait_done(input int limit);
    int start;
    start = n_done;
    for (int i = 0; i < limit && n_done == start; i++) cyc(1);
    if (n_done == start) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within %0d cycles want done", limit);
    end
    cyc(1);
  endtask

  initial begin
    int start;
    bus.data_in   = '0;
    bus.colour_in = '0;
    bus.go        = 1'b0;
`ifdef BOX_DRAWER_CLEAR_EN
    bus.clear_req = 1'b0;
`endif
    cyc(3);
    chk("reset_x", int'(bus.x), 0);
    chk("reset_y", int'(bus.y), 0);
    chk("reset_colour", int'(bus.colour), 0);
    chk("reset_plot", int'(bus.plot), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    reset = 1'b0;
    cyc(2);

    // Basic box; colour_in changes once drawing has begun.
    draw_box(10, 20, 5);
    bus.colour_in = 3'd2;
    wait_done(40);

    // Bottom-right corner: only four pixels land on screen.
    draw_box(158, 118, 3);
    wait_done(40);
    draw_box(156, 116, 7);
    wait_done(40);

    // Reset part-way through a draw.
    draw_box(30, 40, 6);
    start = n_plot;
    for (int i = 0; i < 40 && n_plot < start + 5; i++) cyc(1);
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    cyc(1);
    chk("abort_plot", int'(bus.plot), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    draw_box(12, 34, 4);
    wait_done(40);

    // go held high across completion starts the next x-load.
    draw_box(40, 30, 6);
    bus.data_in = 8'd50;
    bus.go      = 1'b1;
    wait_done(40);
    cyc(1);
    bus.go = 1'b0;
    cyc(1);
    load_y_start(50, 60);
    wait_done(40);

    // Randomised origins, mixing edge-heavy and full-range values.
    for (int n = 0; n < 12; n++) begin
      int xv, yv;
      xv = (n % 2 == 0) ? int'($urandom_range(150, 165)) : int'($urandom_range(0, 255));
      yv = (n % 3 == 0) ? int'($urandom_range(110, 130)) : int'($urandom_range(0, 255));
      draw_box(xv, yv, int'($urandom_range(0, 7)));
      wait_done(40);
    end

`ifdef BOX_DRAWER_CLEAR_EN
    begin
      pix_t p;
      for (int yy = 0; yy < SH; yy++) begin
        for (int xx = 0; xx < SW; xx++) begin
          p.x = X_W'(xx);
          p.y = Y_W'(yy);
          p.c = '0;
          exp_q.push_back(p);
        end
      end
      done_q.push_back(SW * SH);
      bus.clear_req = 1'b1;
      cyc(1);
      bus.clear_req = 1'b0;
      wait_done(SW * SH + 50);
    end
    draw_box(70, 80, 1);
    cyc(3);
    bus.clear_req = 1'b1;
    cyc(4);
    bus.clear_req = 1'b0;
    wait_done(40);
`endif

    cyc(5);
    chk("pixels_left", exp_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
